spi_master_burst: RTL and testbench
===================================

// Module: spi_master_burst
// PURPOSE
//  Parametrised SPI master (mode 3: CPOL=1, CPHA=1) for register-mapped sensors.
//  Sends a header {rw, mb, address} then NBYTES data words, write or read, with
//  programmable SCLK divider and burst length. Sits between sensor-control FSMs
//  and the SPI pins; replaces the fixed 8-bit single-transfer SPI block.
// PARAMETERS
//  ADDR_W     6   register address width; header = 2+ADDR_W bits, MSB first
//  DATA_W     8   data word width, MSB first
//  MAX_BYTES  8   max words per burst; nbytes width NB_W = $clog2(MAX_BYTES+1)
//  CLK_DIV    4   clk cycles per SCLK half-period (>=2)
//  CS_GAP     4   min clk cycles spi_cs stays high between frames
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst        in   1        asynchronous active-high reset
//  start      in   1        frame request; accepted only when busy=0
//  rw         in   1        1=read, 0=write (header bit 0 sent first)
//  address    in   ADDR_W   register address, latched on accept
//  nbytes     in   NB_W     word count 1..MAX_BYTES; mb=(nbytes>1)
//  wr_data    in   DATA_W   write word; sampled on accept and on wr_req
//  wr_req     out  1        1-cycle pulse: next write word sampled this cycle
//  rd_data    out  DATA_W   last received word, held until next rd_valid
//  rd_valid   out  1        1-cycle pulse when rd_data updated
//  busy       out  1        high from accept cycle+1 until frame and gap done
//  done       out  1        1-cycle pulse when spi_cs returns high
//  err        out  1        1-cycle pulse: start rejected (nbytes 0 or >MAX)
//  spi_clk    out  1        SCLK, idles high
//  spi_cs     out  1        chip select, active low
//  spi_mosi   out  1        master out, changes on SCLK falling edge
//  spi_miso   in   1        master in, sampled on SCLK rising edge
// BEHAVIOUR
//  Reset: spi_clk=1, spi_cs=1, spi_mosi=1, busy=0, done=0, wr_req=0,
//   rd_valid=0, err=0, rd_data=0, state=IDLE; reset mid-frame aborts at once.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
//  IDLE: start=1 & valid nbytes latches rw/address/nbytes/wr_data, busy=1 next
//   cycle, go SETUP; invalid nbytes pulses err, stays IDLE. start ignored busy=1.
//  SETUP: spi_cs=0, spi_mosi=header MSB, wait CLK_DIV cycles, go SHIFT.
//  SHIFT: SCLK low CLK_DIV cycles then high CLK_DIV cycles per bit; total bits
//   = (2+ADDR_W) + nbytes*DATA_W, no gap between words. MOSI updates on every
//   falling edge; MISO sampled on every rising edge into shift register.
//  Write: wr_req pulses in the cycle of the rising edge of the last bit of each
//   word except the final; wr_data must be valid in that cycle. Read: MOSI=0.
//  Read: rd_valid pulses cycle after the last-bit rising edge of each data word
//   (not header); rd_data = that word. Write frames never assert rd_valid.
//  HOLD: after last rising edge, SCLK stays high, spi_cs=0 for CLK_DIV cycles,
//   then spi_cs=1, done pulses same cycle, go GAP.
//  GAP: spi_cs=1 for CS_GAP cycles, busy drops on exit; start on the cycle
//   busy=0 is accepted (back-to-back frames).
//  Bit/word counters sized from parameters; no wrap beyond programmed length.
// TESTING
//  Reset: rst pulse mid-idle -> spi_clk=1, spi_cs=1, busy=0, all pulses 0.
//  Write 1 word: rw=0 addr=0x2D wr_data=0x08 -> MOSI bits 0x2D then 0x08
//   (16 bits), done once, no wr_req, no rd_valid, busy low after gap.
//  Read burst: rw=1 addr=0x32 nbytes=6, slave returns 0x11..0x66 -> header
//   0xF2, six rd_valid pulses with rd_data 0x11,0x22,..,0x66 in order.
//  Write burst nbytes=3 data A5,5A,FF -> exactly 2 wr_req pulses, MOSI stream
//   0x6?/header then A5 5A FF; SCLK half-period = CLK_DIV clk cycles exactly.
//  Invalid: start with nbytes=0 and nbytes=MAX_BYTES+1 -> err pulse, spi_cs=1.
//  Abort/back-to-back: rst mid-SHIFT -> pins idle next cycle; start held high
//   -> second frame begins, spi_cs high >= CS_GAP cycles between frames.

Source files
------------

// File: rtl/spi_master_burst.sv
// Mode-3 SPI burst master: sends {rw, mb, address} followed by nbytes data words,
// then holds chip select for one half-period and keeps it high for a minimum gap.
module spi_master_burst #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BYTES = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_GAP    = 4,
    localparam int unsigned NB_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rw,
    input  logic [ADDR_W-1:0] address,
    input  logic [NB_W-1:0]   nbytes,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              spi_clk,
    output logic              spi_cs,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int unsigned HDR_W   = 2 + ADDR_W;
    localparam int unsigned CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BP_MAX  = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int unsigned BP_W    = $clog2(BP_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t            state;
    logic [CNT_W-1:0]  div_cnt;
    logic [BP_W-1:0]   bit_pos;
    logic [NB_W-1:0]   word_cnt;
    logic [NB_W-1:0]   nb_r;
    logic              rw_r;
    logic              in_hdr;
    logic              rd_pend;
    logic [HDR_W-1:0]  hdr_sr;
    logic [DATA_W-1:0] word_sr;
    logic [DATA_W-1:0] rx_sr;

    logic nbytes_ok;
    logic div_end;
    logic gap_end;
    logic field_last;
    logic word_last;

    assign nbytes_ok  = (nbytes != '0) && (nbytes <= NB_W'(MAX_BYTES));
    assign div_end    = (div_cnt == CNT_W'(CLK_DIV - 1));
    assign gap_end    = (div_cnt == CNT_W'(CS_GAP - 1));
    assign field_last = in_hdr ? (bit_pos == BP_W'(HDR_W - 1)) : (bit_pos == BP_W'(DATA_W - 1));
    assign word_last  = (word_cnt == nb_r - NB_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_pos  <= '0;
            word_cnt <= '0;
            nb_r     <= '0;
            rw_r     <= 1'b0;
            in_hdr   <= 1'b1;
            rd_pend  <= 1'b0;
            hdr_sr   <= '0;
            word_sr  <= '0;
            rx_sr    <= '0;
            wr_req   <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            spi_clk  <= 1'b1;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b1;
        end else begin
            wr_req   <= 1'b0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rd_pend  <= 1'b0;

            // received word is presented the cycle after its last rising edge
            if (rd_pend) begin
                rd_valid <= 1'b1;
                rd_data  <= rx_sr;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (nbytes_ok) begin
                            rw_r     <= rw;
                            nb_r     <= nbytes;
                            hdr_sr   <= {rw, (nbytes > NB_W'(1)), address};
                            word_sr  <= wr_data;
                            busy     <= 1'b1;
                            spi_cs   <= 1'b0;
                            spi_mosi <= rw;
                            div_cnt  <= '0;
                            bit_pos  <= '0;
                            word_cnt <= '0;
                            in_hdr   <= 1'b1;
                            state    <= SETUP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                SETUP: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        spi_clk  <= 1'b0;
                        spi_mosi <= hdr_sr[HDR_W-1];
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end

                SHIFT: begin
                    if (wr_req) begin
                        word_sr <= wr_data;
                    end
                    if (!div_end) begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end else if (!spi_clk) begin
                        // rising edge: sample MISO, retire the bit
                        div_cnt <= '0;
                        spi_clk <= 1'b1;
                        rx_sr   <= {rx_sr[DATA_W-2:0], spi_miso};
                        if (in_hdr) begin
                            hdr_sr <= {hdr_sr[HDR_W-2:0], 1'b0};
                        end else begin
                            word_sr <= {word_sr[DATA_W-2:0], 1'b0};
                        end
                        if (field_last) begin
                            bit_pos <= '0;
                            if (in_hdr) begin
                                in_hdr <= 1'b0;
                            end else begin
                                rd_pend <= rw_r;
                                if (word_last) begin
                                    state <= HOLD;
                                end else begin
                                    word_cnt <= word_cnt + NB_W'(1);
                                    wr_req   <= !rw_r;
                                end
                            end
                        end else begin
                            bit_pos <= bit_pos + BP_W'(1);
                        end
                    end else begin
                        // falling edge: present the next bit
                        div_cnt  <= '0;
                        spi_clk  <= 1'b0;
                        spi_mosi <= in_hdr ? hdr_sr[HDR_W-1] : (!rw_r & word_sr[DATA_W-1]);
                    end
                end

                HOLD: begin
                    if (div_end) begin
                        div_cnt  <= '0;
                        spi_cs   <= 1'b1;
                        spi_mosi <= 1'b1;
                        done     <= 1'b1;
                        state    <= GAP;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (gap_end) begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_burst.sv
// Directed bench for spi_master_burst: a small SPI slave/monitor records MOSI,
// drives MISO, counts pulses and measures SCLK half-periods and CS gaps.
module tb_spi_master_burst;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CS_GAP  = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic       rw;
    logic [5:0] address;
    logic [3:0] nbytes;
    logic [7:0] wr_data;
    logic       wr_req;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic       spi_clk;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_miso;

    int errors = 0;
    int checks = 0;

    logic [63:0] cap = '0;
    int nrise = 0, fidx = 0, n_wr = 0, n_rd = 0, n_done = 0, n_err = 0, n_frames = 0;
    int rd_n = 0, hp_min = 1000, hp_max = 0, hp_cnt = 0, run = 0, last_gap = 0;
    logic hp_seen = 1'b0;
    logic prev_sclk = 1'b1, prev_cs = 1'b1;
    logic [7:0] rd_log [0:7];

    spi_master_burst #(
        .ADDR_W(6), .DATA_W(8), .MAX_BYTES(8), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .address(address),
        .nbytes(nbytes), .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
        .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave returns 0 during the header, then 0x11, 0x22, ... per data word
    function automatic logic slave_bit(input int n);
        int w;
        logic [7:0] v;
        if (n < 8) return 1'b0;
        w = (n - 8) / 8;
        v = 8'(8'h11 * (w + 1));
        return v[7 - ((n - 8) % 8)];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_sclk <= 1'b1;
            prev_cs   <= 1'b1;
            spi_miso  <= 1'b1;
        end else begin
            prev_sclk <= spi_clk;
            prev_cs   <= spi_cs;
            if (prev_cs && !spi_cs) begin
                cap      <= '0;
                nrise    <= 0;
                fidx     <= 0;
                n_wr     <= 0;
                n_rd     <= 0;
                n_done   <= 0;
                rd_n     <= 0;
                hp_seen  <= 1'b0;
                hp_min   <= 1000;
                hp_max   <= 0;
                hp_cnt   <= 0;
                last_gap <= run;
                run      <= 0;
                n_frames <= n_frames + 1;
            end else begin
                if (spi_cs) run <= run + 1;
                if (wr_req) n_wr <= n_wr + 1;
                if (done) n_done <= n_done + 1;
                if (err) n_err <= n_err + 1;
                if (rd_valid) begin
                    n_rd <= n_rd + 1;
                    if (rd_n < 8) rd_log[rd_n] <= rd_data;
                    rd_n <= rd_n + 1;
                end
                if (!spi_cs) begin
                    if (spi_clk != prev_sclk) begin
                        if (hp_seen) begin
                            if (hp_cnt < hp_min) hp_min <= hp_cnt;
                            if (hp_cnt > hp_max) hp_max <= hp_cnt;
                        end
                        hp_seen <= 1'b1;
                        hp_cnt  <= 1;
                    end else begin
                        hp_cnt <= hp_cnt + 1;
                    end
                    if (spi_clk && !prev_sclk) begin
                        cap   <= {cap[62:0], spi_mosi};
                        nrise <= nrise + 1;
                    end
                    if (!spi_clk && prev_sclk) begin
                        spi_miso <= slave_bit(fidx);
                        fidx     <= fidx + 1;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < 3000), 64'd1);
        @(negedge clk);
    endtask

    task automatic wait_wr(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wr_req !== 1'b1 && n < 2000);
        check(tag, 64'(n < 2000), 64'd1);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int f0, n;
        rst = 1'b1; start = 1'b0; rw = 1'b0; address = '0; nbytes = 4'd1; wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_sclk", 64'(spi_clk), 64'd1);
        check("rst_cs", 64'(spi_cs), 64'd1);
        check("rst_mosi", 64'(spi_mosi), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pulses", 64'({done, wr_req, rd_valid, err}), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_rst_pins", 64'({spi_clk, spi_cs, busy}), 64'b110);
        rst = 1'b0;
        @(negedge clk);

        // single write word
        rw = 1'b0; address = 6'h2D; nbytes = 4'd1; wr_data = 8'h08;
        pulse_start();
        check("w1_busy", 64'(busy), 64'd1);
        check("w1_cs", 64'(spi_cs), 64'd0);
        wait_idle("w1_timeout");
        check("w1_bits", 64'(nrise), 64'd16);
        check("w1_mosi", 64'(cap[15:0]), 64'h2D08);
        check("w1_done", 64'(n_done), 64'd1);
        check("w1_wr_req", 64'(n_wr), 64'd0);
        check("w1_rd_valid", 64'(n_rd), 64'd0);
        check("w1_busy_low", 64'(busy), 64'd0);

        // read burst of six words
        rw = 1'b1; address = 6'h32; nbytes = 4'd6;
        pulse_start();
        wait_idle("rd_timeout");
        check("rd_bits", 64'(nrise), 64'd56);
        check("rd_header", 64'(cap[55:48]), 64'hF2);
        check("rd_mosi_zero", cap[47:0], 64'd0);
        check("rd_valid_cnt", 64'(n_rd), 64'd6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("rd_word%0d", k), 64'(rd_log[k]), 64'(8'h11 * (k + 1)));
        end
        check("rd_hold", 64'(rd_data), 64'h66);
        check("rd_done", 64'(n_done), 64'd1);

        // write burst of three words fed through wr_req
        rw = 1'b0; address = 6'h2A; nbytes = 4'd3; wr_data = 8'hA5;
        pulse_start();
        wait_wr("wb_req1_timeout");
        wr_data = 8'h5A;
        wait_wr("wb_req2_timeout");
        wr_data = 8'hFF;
        wait_idle("wb_timeout");
        check("wb_bits", 64'(nrise), 64'd32);
        check("wb_mosi", 64'(cap[31:0]), 64'h6AA55AFF);
        check("wb_wr_req", 64'(n_wr), 64'd2);
        check("wb_rd_valid", 64'(n_rd), 64'd0);
        check("wb_half_min", 64'(hp_min), 64'(CLK_DIV));
        check("wb_half_max", 64'(hp_max), 64'(CLK_DIV));

        // invalid word counts
        nbytes = 4'd0;
        pulse_start();
        check("inv0_err", 64'(err), 64'd1);
        check("inv0_pins", 64'({spi_cs, busy}), 64'b10);
        @(negedge clk);
        check("inv0_err_pulse", 64'(err), 64'd0);
        nbytes = 4'd9;
        pulse_start();
        check("inv9_err", 64'(err), 64'd1);
        check("inv9_pins", 64'({spi_cs, busy}), 64'b10);
        @(negedge clk);

        // reset in the middle of a shift
        rw = 1'b0; address = 6'h15; nbytes = 4'd2; wr_data = 8'hC3;
        pulse_start();
        repeat (30) @(negedge clk);
        check("abort_in_frame", 64'({spi_cs, busy}), 64'b01);
        rst = 1'b1;
        #1;
        check("abort_pins", 64'({spi_clk, spi_cs, spi_mosi, busy}), 64'b1110);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back frames with start held high
        f0 = n_frames;
        rw = 1'b0; address = 6'h01; nbytes = 4'd1; wr_data = 8'h3C;
        start = 1'b1;
        n = 0;
        while (n_frames != f0 + 2 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("b2b_timeout", 64'(n < 5000), 64'd1);
        check("b2b_gap", 64'(last_gap >= int'(CS_GAP)), 64'd1);
        wait_idle("b2b_idle_timeout");
        check("b2b_frames", 64'(n_frames - f0), 64'd2);
        check("b2b_mosi", 64'(cap[15:0]), 64'h013C);
        check("b2b_done", 64'(n_done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
